pet_memmap: RTL
===============

# pet_memmap

Parametrised PET memory-map controller: decodes the 6502 address space onto the main RAM, video RAM, ROM and I/O, drives their ports, and registers the CPU read-data mux. It supports RAM size, 40/80-column video RAM and optional-ROM population. It also arbitrates a DMA port (PRG injection, ROM load) against CPU cycles and, optionally, provides 8096-style 64 KB expansion banking via the control register at $FFF0. It sits between the CPU and the RAM/ROM/IO instances in the top-level PET hardware wrapper.

## Interface
- RAM_AW, 15, main RAM address bits (13 = 8 KB, 14 = 16 KB, 15 = 32 KB)
- VRAM_AW, 10, video RAM address bits (10 = 40 col, 11 = 80 col)
- OPTROM_MASK, 2'b11, bit0: $9000 ROM present; bit1: $A000 ROM present

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_cpu  in  1  CPU access strobe; addr/we/data_in valid
- addr  in  16  CPU address
- data_in  in  8  CPU write data
- we  in  1  CPU write
- data_out  out  8  CPU read data, registered
- mem_addr  out  17  physical RAM address: main at 0x00000+, expansion at 0x10000+
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write strobe
- mem_rdata  in  8  RAM read data, one-cycle latency
- vram_addr  out  VRAM_AW  video RAM CPU-side address
- vram_we  out  1  video RAM write
- vram_rdata  in  8  video RAM data, one-cycle latency
- rom_addr  out  15  ROM address
- rom_rdata  in  8  ROM data, one-cycle latency
- io_cs  out  1  $E8xx select, qualified by ce_cpu
- io_rdata  in  8  I/O read data, combinational
- dma_req  in  1  DMA request, held until dma_ack
- dma_addr  in  17  DMA physical address
- dma_din  in  8  DMA write data
- dma_we  in  1  DMA write
- dma_dout  out  8  DMA read data, valid with dma_ack
- dma_ack  out  1  one-cycle completion pulse
- bank_ctrl  out  8  current $FFF0 register

## Operation
- Decode map:
  - $0000–$7FFF: RAM. Addresses at or above 2^RAM_AW are unmapped.
  - $8000–$8FFF: VRAM, mirrored modulo 2^VRAM_AW.
  - $9000–$AFFF: option ROMs if their OPTROM_MASK bit is set, else unmapped.
  - $B000–$E7FF: ROM.
  - $E800–$EFFF: I/O.
  - $F000–$FFFF: ROM.
- Unmapped reads return addr[15:8] (open bus). ROM and unmapped writes are dropped.
- Read mux: the region is latched on the ce_cpu cycle, and data_out is selected from the latched region on the following cycle. The I/O byte is captured in the ce_cpu cycle.
- DMA FSM:
  - IDLE → ISSUE: when dma_req=1 and ce_cpu=0. Drive mem_addr=dma_addr, and mem_we=dma_we when dma_addr[16]=0 or expansion is built in.
  - ISSUE → ACK: capture mem_rdata into dma_dout and pulse dma_ack.
  - ACK → IDLE.
- CPU has priority. If ce_cpu and dma_req are both asserted, the CPU wins and DMA waits. A CPU access never coincides with ISSUE: ce_cpu arriving during ISSUE is serviced, and DMA re-issues next free cycle without acking.
- Reset mid-DMA: state returns to IDLE, no ack, and the requester must re-request.

## Timing
- CPU read: data_out valid 1 cycle after ce_cpu and held until the next ce_cpu.
- CPU write: mem_we, vram_we and io_cs asserted in the ce_cpu cycle only.
- DMA latency: 2 cycles minimum from a grantable dma_req to dma_ack.
- Reset values:
  - data_out = 8'h00
  - mem_we = vram_we = io_cs = dma_ack = 0
  - dma_dout = 8'h00
  - bank_ctrl = 8'h00
  - FSM = IDLE
- Strobes (mem_we, vram_we, io_cs) are never active outside ce_cpu or ISSUE.

## Configuration
- PET_8096_EXPANSION_EN defined:
  - A CPU write to $FFF0 loads bank_ctrl. The write is not forwarded to memory.
  - bank_ctrl[7]=1 maps $8000–$FFFF to expansion RAM:
    - $8000–$BFFF → block bank_ctrl[2] ? 2 : 0.
    - $C000–$FFFF → block bank_ctrl[3] ? 3 : 1.
    - The physical address is 0x10000 + block*0x4000 + addr[13:0].
  - Peek-through: bank_ctrl[6] keeps $E800–$EFFF as I/O; bank_ctrl[5] keeps $8000–$8FFF as VRAM.
  - Write protect: bank_ctrl[0] drops expansion writes in $8000–$BFFF; bank_ctrl[1] drops them in $C000–$FFFF.
  - DMA may access 0x10000+.
- Undefined:
  - bank_ctrl is held at 0.
  - $FFF0 is ordinary ROM.
  - DMA writes with dma_addr[16]=1 are dropped; DMA reads return 8'hFF.

## Structure
- The shared package pet_pkg holds:
  - the region enum: RAM, VRAM, OPT9, OPTA, ROM, IO, UNMAP, EXP
  - constants: BANK_REG_ADDR = 16'hFFF0, EXP_BASE = 17'h10000, and the bank_ctrl bit indices.
- One sub-module, pet_memmap_decode: combinational addr + bank_ctrl → region and physical address. It is instantiated twice, for the CPU path and the DMA write-enable check.

## Test plan
- Reset, then CPU reads $0100 after a DMA write of 8'hA5 to 0x00100 → dma_ack after 2 cycles; data_out = 8'hA5 one cycle after ce_cpu.
- RAM_AW=13: read $4000 → 8'h40. With OPTROM_MASK=2'b00, read $9123 → 8'h91.
- VRAM_AW=10: write 8'h3C to $8400 → vram_addr=0, vram_we for 1 cycle; read $8000 → 8'h3C.
- dma_req held while ce_cpu pulses every cycle for 4 cycles → no ack during them; ack 2 cycles after ce_cpu stops. Reset asserted in ISSUE → no ack, FSM idle.
- With PET_8096_EXPANSION_EN:
  - Write 8'h84 to $FFF0, then write 8'h5A to $9000 → mem_addr=0x19000, mem_we=1.
  - Write 8'h85 to $FFF0, then write to $9000 → no mem_we.
  - Write 8'hC0 to $FFF0, then access $E810 → io_cs=1.
- Without PET_8096_EXPANSION_EN: write to $FFF0 → bank_ctrl stays 8'h00. DMA read of 0x10000 → dma_dout = 8'hFF.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared PET memory-map types and constants.
// PET_8096_EXPANSION_EN selects the 8096 64 KB expansion banking build.
package pet_pkg;
  typedef enum logic [2:0] {
    RGN_RAM, RGN_VRAM, RGN_OPT9, RGN_OPTA, RGN_ROM, RGN_IO, RGN_UNMAP, RGN_EXP
  } region_e;

  localparam logic [15:0] BANK_REG_ADDR = 16'hFFF0;
  localparam logic [16:0] EXP_BASE      = 17'h10000;

  localparam int BC_WP_LO   = 0;
  localparam int BC_WP_HI   = 1;
  localparam int BC_BLK_LO  = 2;
  localparam int BC_BLK_HI  = 3;
  localparam int BC_VRAM_PT = 5;
  localparam int BC_IO_PT   = 6;
  localparam int BC_EN      = 7;

`ifdef PET_8096_EXPANSION_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif
endpackage

// File: rtl/pet_memmap_decode.sv
// Combinational PET address decoder: CPU address + bank_ctrl -> region, physical address, write permission.
// phys_hi marks a physical access above 64 KB (DMA), which always targets expansion RAM.
module pet_memmap_decode import pet_pkg::*; #(
  parameter int         RAM_AW      = 15,
  parameter logic [1:0] OPTROM_MASK = 2'b11
) (
  input  logic [15:0] addr,
  input  logic        phys_hi,
  input  logic [7:0]  bank_ctrl,
  output region_e     region,
  output logic [16:0] phys,
  output logic        wr_ok
);
  localparam logic [16:0] RAM_TOP = 17'd1 << RAM_AW;

  logic       io_win, vram_win;
  logic [1:0] blk;
  logic       unused_bc4;

  assign unused_bc4 = bank_ctrl[4];

  always_comb begin
    io_win   = (addr[15:11] == 5'b11101);
    vram_win = (addr[15:12] == 4'h8);
    blk      = addr[14] ? {bank_ctrl[BC_BLK_HI], 1'b1} : {bank_ctrl[BC_BLK_LO], 1'b0};
    region   = RGN_ROM;
    phys     = {1'b0, addr};
    if (!addr[15])                region = ({1'b0, addr} < RAM_TOP) ? RGN_RAM : RGN_UNMAP;
    else if (vram_win)            region = RGN_VRAM;
    else if (addr[15:12] == 4'h9) region = OPTROM_MASK[0] ? RGN_OPT9 : RGN_UNMAP;
    else if (addr[15:12] == 4'hA) region = OPTROM_MASK[1] ? RGN_OPTA : RGN_UNMAP;
    else if (io_win)              region = RGN_IO;
    // banked upper half, except the enabled peek-through windows
    if (EXP_EN && bank_ctrl[BC_EN] && addr[15] &&
        !(bank_ctrl[BC_IO_PT] && io_win) && !(bank_ctrl[BC_VRAM_PT] && vram_win)) begin
      region = RGN_EXP;
      phys   = EXP_BASE | {1'b0, blk, addr[13:0]};
    end
    if (phys_hi) begin
      region = RGN_EXP;
      phys   = EXP_BASE | {1'b0, addr};
    end
    case (region)
      RGN_RAM, RGN_VRAM, RGN_IO: wr_ok = 1'b1;
      RGN_EXP: wr_ok = phys_hi ? EXP_EN
                               : !(addr[14] ? bank_ctrl[BC_WP_HI] : bank_ctrl[BC_WP_LO]);
      default: wr_ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/pet_memmap.sv
// PET memory-map controller: CPU decode, registered read mux and DMA arbitration.
// Define PET_8096_EXPANSION_EN to build the $FFF0 bank register and 64 KB expansion.
module pet_memmap import pet_pkg::*; #(
  parameter int         RAM_AW      = 15,
  parameter int         VRAM_AW     = 10,
  parameter logic [1:0] OPTROM_MASK = 2'b11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_cpu,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_in,
  input  logic               we,
  output logic [7:0]         data_out,
  output logic [16:0]        mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               mem_we,
  input  logic [7:0]         mem_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  input  logic [7:0]         vram_rdata,
  output logic [14:0]        rom_addr,
  input  logic [7:0]         rom_rdata,
  output logic               io_cs,
  input  logic [7:0]         io_rdata,
  input  logic               dma_req,
  input  logic [16:0]        dma_addr,
  input  logic [7:0]         dma_din,
  input  logic               dma_we,
  output logic [7:0]         dma_dout,
  output logic               dma_ack,
  output logic [7:0]         bank_ctrl
);
  typedef enum logic [1:0] {DMA_IDLE, DMA_ISSUE, DMA_ACK} dma_state_e;

  dma_state_e  state_q, state_d;
  region_e     cpu_rgn, rgn_q, unused_dma_rgn;
  logic [16:0] cpu_phys, unused_dma_phys;
  logic        cpu_wr_ok, dma_dec_ok, bank_wr, dma_go, dma_blk_q, rd_pend;
  logic [7:0]  bank_q, io_q, open_q, data_q, rd_mux, dma_rd, dma_dout_q;

  pet_memmap_decode #(.RAM_AW(RAM_AW), .OPTROM_MASK(OPTROM_MASK)) u_cpu_dec (
    .addr(addr), .phys_hi(1'b0), .bank_ctrl(bank_q),
    .region(cpu_rgn), .phys(cpu_phys), .wr_ok(cpu_wr_ok));

  pet_memmap_decode #(.RAM_AW(RAM_AW), .OPTROM_MASK(OPTROM_MASK)) u_dma_dec (
    .addr(dma_addr[15:0]), .phys_hi(dma_addr[16]), .bank_ctrl(8'h00),
    .region(unused_dma_rgn), .phys(unused_dma_phys), .wr_ok(dma_dec_ok));

  assign bank_wr   = EXP_EN & ce_cpu & we & (addr == BANK_REG_ADDR);
  assign bank_ctrl = bank_q;

`ifdef PET_8096_EXPANSION_EN
  always_ff @(posedge clk) begin
    if (reset)        bank_q <= 8'h00;
    else if (bank_wr) bank_q <= data_in;
  end
`else
  assign bank_q = 8'h00;
`endif

  // CPU owns the RAM port whenever ce_cpu is up, even mid-DMA
  assign dma_go = (state_q == DMA_ISSUE) && !ce_cpu;

  always_comb begin
    mem_addr  = cpu_phys;
    mem_wdata = data_in;
    mem_we    = ce_cpu & we & cpu_wr_ok & ~bank_wr & ((cpu_rgn == RGN_RAM) || (cpu_rgn == RGN_EXP));
    if (dma_go) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_din;
      mem_we    = dma_we & (~dma_addr[16] | dma_dec_ok);
    end
  end

  assign vram_addr = addr[VRAM_AW-1:0];
  assign vram_we   = ce_cpu & we & (cpu_rgn == RGN_VRAM);
  assign rom_addr  = addr[14:0];
  assign io_cs     = ce_cpu & (cpu_rgn == RGN_IO);

  always_comb begin
    case (rgn_q)
      RGN_RAM, RGN_EXP:            rd_mux = mem_rdata;
      RGN_VRAM:                    rd_mux = vram_rdata;
      RGN_OPT9, RGN_OPTA, RGN_ROM: rd_mux = rom_rdata;
      RGN_IO:                      rd_mux = io_q;
      default:                     rd_mux = open_q;
    endcase
  end

  // memories answer one cycle late, so the fresh byte is muxed straight out then held
  assign data_out = rd_pend ? rd_mux : data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rgn_q   <= RGN_UNMAP;
      io_q    <= 8'h00;
      open_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      rd_pend <= ce_cpu & ~we;
      if (ce_cpu) begin
        rgn_q  <= cpu_rgn;
        io_q   <= io_rdata;
        open_q <= addr[15:8];
      end
      if (rd_pend) data_q <= rd_mux;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DMA_IDLE:  if (dma_req && !ce_cpu) state_d = DMA_ISSUE;
      DMA_ISSUE: state_d = ce_cpu ? DMA_IDLE : DMA_ACK;
      default:   state_d = DMA_IDLE;
    endcase
  end

  assign dma_ack  = (state_q == DMA_ACK);
  assign dma_rd   = dma_blk_q ? 8'hFF : mem_rdata;
  assign dma_dout = dma_ack ? dma_rd : dma_dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DMA_IDLE;
      dma_blk_q  <= 1'b0;
      dma_dout_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (dma_go)  dma_blk_q  <= dma_addr[16] & ~dma_dec_ok;
      if (dma_ack) dma_dout_q <= dma_rd;
    end
  end
endmodule
